// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver with clock glitch filter, E0/F0 prefix decoding and frame timeout
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] oScanCode,
    output logic       oValid,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oError,
    output logic       oBusy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateType;

    stateType state, stateNext;
    logic [1:0] clkSync, dataSync;
    logic filtClk;
    logic [FW-1:0] filtCnt;
    logic [TW-1:0] toCnt;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic parityBit, pendBreak, pendExt;
    logic dataIn, sampleEv, timeout, stopEv, frameGood, isPrefix;

    // a sample fires on the same edge that commits the filtered clock's fall
    assign dataIn    = dataSync[1];
    assign sampleEv  = filtClk & ~clkSync[1] & (filtCnt == FILT_MAX);
    assign timeout   = (state != IDLE) & ~sampleEv & (toCnt == TO_MAX);
    assign stopEv    = sampleEv & (state == STOP);
    assign frameGood = dataIn & ^{shiftReg, parityBit};
    assign isPrefix  = (shiftReg == 8'hE0) || (shiftReg == 8'hF0);
    assign oBusy     = state != IDLE;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkSync  <= '1;
            dataSync <= '1;
            filtClk  <= 1'b1;
            filtCnt  <= '0;
        end else begin
            clkSync  <= {clkSync[0], PS2_CLK};
            dataSync <= {dataSync[0], PS2_DATA};
            filtCnt  <= (clkSync[1] == filtClk || filtCnt == FILT_MAX) ? '0 : filtCnt + 1'b1;
            if (clkSync[1] != filtClk && filtCnt == FILT_MAX) filtClk <= clkSync[1];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        if (timeout) stateNext = IDLE;
        else if (sampleEv)
            case (state)
                IDLE:    stateNext = dataIn ? IDLE : DATA;
                DATA:    stateNext = (bitCnt == 3'd7) ? PARITY : DATA;
                PARITY:  stateNext = STOP;
                default: stateNext = IDLE;
            endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            toCnt     <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            pendBreak <= 1'b0;
            pendExt   <= 1'b0;
            oScanCode <= '0;
            oValid    <= 1'b0;
            oBreak    <= 1'b0;
            oExtended <= 1'b0;
            oError    <= 1'b0;
        end else begin
            oValid <= 1'b0;
            oError <= 1'b0;
            toCnt  <= (sampleEv || state == IDLE) ? '0 : toCnt + 1'b1;
            if (sampleEv && state == IDLE) bitCnt <= '0;
            if (sampleEv && state == DATA) begin
                shiftReg <= {dataIn, shiftReg[7:1]};
                bitCnt   <= bitCnt + 1'b1;
            end
            if (sampleEv && state == PARITY) parityBit <= dataIn;
            if (timeout) begin
                oError    <= 1'b1;
                pendBreak <= 1'b0;
                pendExt   <= 1'b0;
                shiftReg  <= '0;
            end else if (stopEv && !frameGood) begin
                oError    <= 1'b1;
                pendBreak <= 1'b0;
                pendExt   <= 1'b0;
            end else if (stopEv && isPrefix) begin
                pendExt   <= pendExt | (shiftReg == 8'hE0);
                pendBreak <= pendBreak | (shiftReg == 8'hF0);
            end else if (stopEv) begin
                oScanCode <= shiftReg;
                oBreak    <= pendBreak;
                oExtended <= pendExt;
                oValid    <= 1'b1;
                pendBreak <= 1'b0;
                pendExt   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed PS/2 frames against a scoreboard of expected code/error events
module tb_ps2_keyboard_rx;
    localparam int FILT = 8;
    localparam int TO = 500;
    localparam int HALF = 40;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic PS2_CLK = 1'b1;
    logic PS2_DATA = 1'b1;
    logic [7:0] oScanCode;
    logic oValid, oBreak, oExtended, oError, oBusy;

    ps2_keyboard_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .oScanCode(oScanCode), .oValid(oValid), .oBreak(oBreak), .oExtended(oExtended),
        .oError(oError), .oBusy(oBusy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       isErr;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        int         errCyc;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int cyc = 0;
    int checks = 0;
    int passCnt = 0;
    int failCnt = 0;
    int lastFallCyc = 0;
    logic [7:0] modelCode = 8'h00;
    logic modelBrk = 1'b0, modelExt = 1'b0, pendB = 1'b0, pendE = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic pushExp(input logic isErr, input int errCyc);
        exp_t x;
        x.isErr = isErr;
        x.code = modelCode;
        x.brk = modelBrk;
        x.ext = modelExt;
        x.errCyc = errCyc;
        sb.push_back(x);
    endtask

    task automatic expectFrame(input logic [7:0] b, input logic good);
        if (!good) begin
            pushExp(1'b1, 0);
            pendB = 1'b0;
            pendE = 1'b0;
        end else if (b == 8'hE0) pendE = 1'b1;
        else if (b == 8'hF0) pendB = 1'b1;
        else begin
            modelCode = b;
            modelBrk = pendB;
            modelExt = pendE;
            pushExp(1'b0, 0);
            pendB = 1'b0;
            pendE = 1'b0;
        end
    endtask

    task automatic ps2Bit(input logic b);
        PS2_DATA = b;
        waitCyc(HALF / 2);
        PS2_CLK = 1'b0;
        lastFallCyc = cyc;
        waitCyc(HALF);
        PS2_CLK = 1'b1;
        waitCyc(HALF / 2);
    endtask

    task automatic frame(input logic [7:0] b, input logic parErr = 1'b0, input logic stopBit = 1'b1);
        expectFrame(b, !parErr && stopBit);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(b[i]);
        ps2Bit(~^b ^ parErr);
        ps2Bit(stopBit);
        PS2_DATA = 1'b1;
        waitCyc(30);
    endtask

    task automatic chkIdleOutputs(input string tag);
        chk({tag, "Code"}, 32'(oScanCode), 32'h0);
        chk({tag, "Flags"}, 32'({oValid, oBreak, oExtended, oError, oBusy}), 32'h0);
    endtask

    always @(negedge Clock) begin
        if (Reset && (oValid || oError)) begin
            if (sb.size() == 0) chk("unexpectedOut", 32'({oValid, oError}), 32'h0);
            else begin
                got = sb.pop_front();
                chk("kind", 32'({oValid, oError}), got.isErr ? 32'h1 : 32'h2);
                chk("code", 32'(oScanCode), 32'(got.code));
                chk("break", 32'(oBreak), 32'(got.brk));
                chk("extended", 32'(oExtended), 32'(got.ext));
                if (got.errCyc != 0) begin
                    chk("timeoutCycle", 32'(cyc), 32'(got.errCyc));
                    chk("timeoutBusy", 32'(oBusy), 32'h0);
                end
            end
        end
    end

    initial begin
        logic [7:0] partial;
        waitCyc(5);
        chkIdleOutputs("reset");
        Reset = 1'b1;
        waitCyc(10);

        frame(8'h1C);
        frame(8'hF0);
        frame(8'h1C);
        frame(8'h1C);
        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);
        frame(8'h1C, 1'b1, 1'b1);
        frame(8'h1C, 1'b0, 1'b0);

        partial = 8'h1C;
        ps2Bit(1'b0);
        for (int i = 0; i < 4; i++) ps2Bit(partial[i]);
        chk("busyMidFrame", 32'(oBusy), 32'h1);
        pushExp(1'b1, lastFallCyc + FILT + 2 + TO);
        waitCyc(TO + 50);
        chk("busyAfterTimeout", 32'(oBusy), 32'h0);
        frame(8'h1C);

        PS2_DATA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            PS2_CLK = 1'b0;
            waitCyc(FILT - 2);
            PS2_CLK = 1'b1;
            waitCyc(20);
            chk("glitchBusy", 32'(oBusy), 32'h0);
        end
        PS2_DATA = 1'b1;
        waitCyc(20);

        frame(8'hF0);
        partial = 8'h2A;
        ps2Bit(1'b0);
        for (int i = 0; i < 3; i++) ps2Bit(partial[i]);
        PS2_DATA = partial[3];
        waitCyc(HALF / 2);
        PS2_CLK = 1'b0;
        waitCyc(HALF / 2);
        Reset = 1'b0;
        waitCyc(2);
        chkIdleOutputs("midReset");
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        modelCode = 8'h00;
        modelBrk = 1'b0;
        modelExt = 1'b0;
        pendB = 1'b0;
        pendE = 1'b0;
        waitCyc(5);
        Reset = 1'b1;
        waitCyc(30);
        chk("idleAfterReset", 32'({oValid, oError, oBusy}), 32'h0);
        frame(8'h1C);

        waitCyc(100);
        chk("scoreboardEmpty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passCnt, checks);
        $finish;
    end
endmodule
